// File: rtl/ssp_gen2.sv
// Second-generation synchronous serial port: TX/RX FIFOs, TI frame-sync transmit
// engine and a PCLK-synchronous receive front end with internal loopback.

module ssp_gen2_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q + AW'(push);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;
  assign full  = full_q;
endmodule

module ssp_gen2 #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 2
) (
  input  logic                        PCLK,
  input  logic                        CLEAR_B,
  input  logic                        PSEL,
  input  logic                        PWRITE,
  input  logic [DATA_W-1:0]           PWDATA,
  output logic [DATA_W-1:0]           PRDATA,
  input  logic                        LOOPBACK,
  input  logic                        SSPCLKIN,
  input  logic                        SSPFSSIN,
  input  logic                        SSPRXD,
  output logic                        SSPCLKOUT,
  output logic                        SSPFSSOUT,
  output logic                        SSPTXD,
  output logic                        SSPOE_B,
  output logic                        SSPTXINTR,
  output logic                        SSPRXINTR,
  output logic [$clog2(FIFO_DEPTH):0] TX_COUNT,
  output logic [$clog2(FIFO_DEPTH):0] RX_COUNT,
  output logic                        RX_OVR
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int DVW = $clog2(CLK_DIV);
  localparam int BW  = $clog2(DATA_W);

  typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_SHIFT} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_WAIT, RX_SHIFT} rx_state_e;

  tx_state_e   tx_state_q, tx_state_d;
  rx_state_e   rx_state_q, rx_state_d;
  logic [DVW-1:0]    div_q, div_d;
  logic              sclk_q, sclk_d, tick_s;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [BW-1:0]     bit_q, bit_d, rx_cnt_q, rx_cnt_d;
  logic              fss_q, fss_d, txd_q, txd_d, oe_b_q, oe_b_d;
  logic [DATA_W-2:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_word_s, tx_head_s, rx_head_s;
  logic [2:0]        meta_q, sync_q;
  logic              rclk_prev_q, rclk_s, rfss_s, rd_s, sample_s;
  logic              tx_push_s, tx_pop_s, rx_push_s, rx_push_ok_s, rx_pop_s;
  logic              tx_empty_s, rx_full_now_s, ovr_q, ovr_d, tx_full_s, rx_full_s;
  logic [CW-1:0]     tx_count_s, rx_count_s;

  assign tx_empty_s    = (tx_count_s == CW'(0));
  assign rx_full_now_s = (rx_count_s == CW'(FIFO_DEPTH));
  assign tx_push_s     = PSEL & PWRITE & (tx_count_s != CW'(FIFO_DEPTH));
  assign rx_pop_s      = PSEL & ~PWRITE & (rx_count_s != CW'(0));
  // A same-cycle bus pop frees the slot the incoming word needs.
  assign rx_push_ok_s  = rx_push_s & (~rx_full_now_s | rx_pop_s);

  always_comb begin
    tick_s = (div_q == DVW'(CLK_DIV - 1));
    if (tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DVW'(1);
    end
    sclk_d = (div_d < DVW'(CLK_DIV / 2));
    ovr_d  = ovr_q | (rx_push_s & rx_full_now_s & ~rx_pop_s);
  end

  // Loopback taps the registered transmit outputs, so no synchronizer is needed there.
  always_comb begin
    if (LOOPBACK) begin
      rclk_s = sclk_q;
      rfss_s = fss_q;
      rd_s   = txd_q;
    end else begin
      rclk_s = sync_q[2];
      rfss_s = sync_q[1];
      rd_s   = sync_q[0];
    end
    sample_s = rclk_prev_q & ~rclk_s;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    bit_d      = bit_q;
    fss_d      = fss_q;
    txd_d      = txd_q;
    oe_b_d     = oe_b_q;
    tx_pop_s   = 1'b0;
    if (tick_s) begin
      case (tx_state_q)
        TX_IDLE: begin
          if (!tx_empty_s) begin
            tx_pop_s   = 1'b1;
            tx_sh_d    = tx_head_s;
            fss_d      = 1'b1;
            tx_state_d = TX_SYNC;
          end else begin
            fss_d  = 1'b0;
            txd_d  = 1'b0;
            oe_b_d = 1'b1;
          end
        end
        TX_SYNC: begin
          fss_d      = 1'b0;
          oe_b_d     = 1'b0;
          txd_d      = tx_sh_q[DATA_W-1];
          bit_d      = BW'(DATA_W - 1);
          tx_state_d = TX_SHIFT;
        end
        TX_SHIFT: begin
          if (bit_q != BW'(0)) begin
            bit_d = bit_q - BW'(1);
            txd_d = tx_sh_q[bit_q - BW'(1)];
            // Fetch the next word alongside bit 0 so frames run back to back.
            if ((bit_q == BW'(1)) && !tx_empty_s) begin
              tx_pop_s = 1'b1;
              tx_sh_d  = tx_head_s;
              fss_d    = 1'b1;
            end else begin
              fss_d = 1'b0;
            end
          end else if (fss_q) begin
            fss_d = 1'b0;
            txd_d = tx_sh_q[DATA_W-1];
            bit_d = BW'(DATA_W - 1);
          end else begin
            oe_b_d     = 1'b1;
            txd_d      = 1'b0;
            tx_state_d = TX_IDLE;
          end
        end
        default: begin
          fss_d      = 1'b0;
          txd_d      = 1'b0;
          oe_b_d     = 1'b1;
          tx_state_d = TX_IDLE;
        end
      endcase
    end else begin
      tx_state_d = tx_state_q;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_sh_d    = rx_sh_q;
    rx_cnt_d   = rx_cnt_q;
    rx_push_s  = 1'b0;
    rx_word_s  = {rx_sh_q, rd_s};
    if (sample_s) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rfss_s) begin
            rx_state_d = RX_WAIT;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end
        RX_WAIT: begin
          rx_sh_d    = rx_word_s[DATA_W-2:0];
          rx_cnt_d   = BW'(1);
          rx_state_d = RX_SHIFT;
        end
        RX_SHIFT: begin
          rx_sh_d = rx_word_s[DATA_W-2:0];
          if (rx_cnt_q == BW'(DATA_W - 1)) begin
            rx_push_s  = 1'b1;
            rx_cnt_d   = '0;
            rx_state_d = rfss_s ? RX_WAIT : RX_IDLE;
          end else begin
            rx_cnt_d = rx_cnt_q + BW'(1);
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end else begin
      rx_state_d = rx_state_q;
    end
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      div_q       <= '0;
      sclk_q      <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_sh_q     <= '0;
      bit_q       <= '0;
      fss_q       <= 1'b0;
      txd_q       <= 1'b0;
      oe_b_q      <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_sh_q     <= '0;
      rx_cnt_q    <= '0;
      meta_q      <= '0;
      sync_q      <= '0;
      rclk_prev_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      div_q       <= div_d;
      sclk_q      <= sclk_d;
      tx_state_q  <= tx_state_d;
      tx_sh_q     <= tx_sh_d;
      bit_q       <= bit_d;
      fss_q       <= fss_d;
      txd_q       <= txd_d;
      oe_b_q      <= oe_b_d;
      rx_state_q  <= rx_state_d;
      rx_sh_q     <= rx_sh_d;
      rx_cnt_q    <= rx_cnt_d;
      meta_q      <= {SSPCLKIN, SSPFSSIN, SSPRXD};
      sync_q      <= meta_q;
      rclk_prev_q <= rclk_s;
      ovr_q       <= ovr_d;
    end
  end

  ssp_gen2_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(PCLK), .rst_n(CLEAR_B), .push(tx_push_s), .pop(tx_pop_s), .wdata(PWDATA),
    .rdata(tx_head_s), .count(tx_count_s), .full(tx_full_s)
  );

  ssp_gen2_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(PCLK), .rst_n(CLEAR_B), .push(rx_push_ok_s), .pop(rx_pop_s), .wdata(rx_word_s),
    .rdata(rx_head_s), .count(rx_count_s), .full(rx_full_s)
  );

  assign PRDATA    = (rx_count_s == CW'(0)) ? '0 : rx_head_s;
  assign SSPCLKOUT = sclk_q;
  assign SSPFSSOUT = fss_q;
  assign SSPTXD    = txd_q;
  assign SSPOE_B   = oe_b_q;
  assign SSPTXINTR = tx_full_s;
  assign SSPRXINTR = rx_full_s;
  assign TX_COUNT  = tx_count_s;
  assign RX_COUNT  = rx_count_s;
  assign RX_OVR    = ovr_q;
endmodule

// File: tb/tb_ssp_gen2.sv
// Directed + randomized bench for ssp_gen2: default instance (8b/depth 4/div 2)
// and a parametric instance (12b/depth 8/div 6) driven from external pins.

module tb_ssp_gen2;
  logic        PCLK = 1'b0;
  logic        CLEAR_B;
  logic        psel0, pwrite0, lb0, clkin0, fssin0, rxd0;
  logic [7:0]  pwdata0, prdata0;
  logic        sclk0, fss0, txd0, oeb0, txi0, rxi0, ovr0;
  logic [2:0]  txc0, rxc0;
  logic        psel1, pwrite1, lb1, eclk, efss, erxd;
  logic [11:0] pwdata1, prdata1;
  logic        sclk1, fss1, txd1, oeb1, txi1, rxi1, ovr1;
  logic [3:0]  txc1, rxc1;

  int n_assert = 0;
  int n_fail   = 0;
  logic [2:0]  per_q [$];
  logic [7:0]  dec_q [$];
  int          pos_q [$];
  logic [7:0]  mq [$];
  logic [7:0]  w [6];
  logic [11:0] w2;
  int start, j, cnt, oe_err, n;

  ssp_gen2 u0 (
    .PCLK(PCLK), .CLEAR_B(CLEAR_B), .PSEL(psel0), .PWRITE(pwrite0), .PWDATA(pwdata0),
    .PRDATA(prdata0), .LOOPBACK(lb0), .SSPCLKIN(clkin0), .SSPFSSIN(fssin0), .SSPRXD(rxd0),
    .SSPCLKOUT(sclk0), .SSPFSSOUT(fss0), .SSPTXD(txd0), .SSPOE_B(oeb0), .SSPTXINTR(txi0),
    .SSPRXINTR(rxi0), .TX_COUNT(txc0), .RX_COUNT(rxc0), .RX_OVR(ovr0)
  );

  ssp_gen2 #(.DATA_W(12), .FIFO_DEPTH(8), .CLK_DIV(6)) u1 (
    .PCLK(PCLK), .CLEAR_B(CLEAR_B), .PSEL(psel1), .PWRITE(pwrite1), .PWDATA(pwdata1),
    .PRDATA(prdata1), .LOOPBACK(lb1), .SSPCLKIN(eclk), .SSPFSSIN(efss), .SSPRXD(erxd),
    .SSPCLKOUT(sclk1), .SSPFSSOUT(fss1), .SSPTXD(txd1), .SSPOE_B(oeb1), .SSPTXINTR(txi1),
    .SSPRXINTR(rxi1), .TX_COUNT(txc1), .RX_COUNT(rxc1), .RX_OVR(ovr1)
  );

  initial forever #5 PCLK = ~PCLK;

  // One entry per SSPCLKOUT period of u0: {frame sync, output enable, data}.
  always @(negedge PCLK) if (sclk0 === 1'b1) per_q.push_back({fss0, oeb0, txd0});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge PCLK);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_u0"}, {sclk0, fss0, txd0, oeb0, txi0, rxi0, ovr0, txc0, rxc0, prdata0},
        {7'b0001000, 3'd0, 3'd0, 8'h00});
    chk({tag, "_u1"}, {sclk1, fss1, txd1, oeb1, txi1, rxi1, ovr1, txc1, rxc1, prdata1},
        {7'b0001000, 4'd0, 4'd0, 12'h000});
  endtask

  task automatic wr0(input logic [7:0] d);
    psel0 = 1'b1; pwrite0 = 1'b1; pwdata0 = d;
    @(posedge PCLK); #1;
    psel0 = 1'b0; pwrite0 = 1'b0;
  endtask

  task automatic rd0(input string tag, input logic [7:0] exp);
    psel0 = 1'b1; pwrite0 = 1'b0; #1;
    chk(tag, prdata0, exp);
    @(posedge PCLK); #1;
    psel0 = 1'b0;
  endtask

  task automatic rd1(input string tag, input logic [11:0] exp);
    psel1 = 1'b1; pwrite1 = 1'b0; #1;
    chk(tag, prdata1, exp);
    @(posedge PCLK); #1;
    psel1 = 1'b0;
  endtask

  // A frame is a sync period followed by 8 data periods; the next sync may share bit 0.
  task automatic decode(input int from);
    int i;
    logic [7:0] v;
    dec_q.delete(); pos_q.delete(); oe_err = 0;
    i = from;
    while (i + 8 < per_q.size()) begin
      if (per_q[i][2]) begin
        v = 8'h00;
        for (int k = 1; k <= 8; k++) begin
          v = {v[6:0], per_q[i+k][0]};
          if (per_q[i+k][1] !== 1'b0) oe_err++;
        end
        dec_q.push_back(v); pos_q.push_back(i);
        i += 8;
      end else begin
        i++;
      end
    end
  endtask

  task automatic ext_period(input logic f, input logic d);
    eclk = 1'b1; efss = f; erxd = d;
    cyc(4);
    eclk = 1'b0;
    cyc(4);
  endtask

  initial begin
    CLEAR_B = 1'b0;
    psel0 = 1'b0; pwrite0 = 1'b0; pwdata0 = 8'h00; lb0 = 1'b0;
    clkin0 = 1'b0; fssin0 = 1'b0; rxd0 = 1'b0;
    psel1 = 1'b0; pwrite1 = 1'b0; pwdata1 = 12'h000; lb1 = 1'b0;
    eclk = 1'b0; efss = 1'b0; erxd = 1'b0;
    #23;
    chk_rst("reset");
    CLEAR_B = 1'b1;
    cyc(3);

    // Single word 0xA5: sync period, 8 MSB-first data periods, then idle.
    start = per_q.size();
    wr0(8'hA5);
    cyc(40);
    j = -1;
    for (int i = start; i < per_q.size(); i++) if (j < 0 && per_q[i][2]) j = i;
    chk("t1_latency", (j >= start) && (j <= start + 1), 1'b1);
    if (j < 0) j = start;
    chk("t1_sync", per_q[j], 3'b110);
    for (int k = 1; k <= 8; k++) chk("t1_bit", per_q[j+k], {2'b00, 1'((8'hA5 >> (8 - k)) & 1)});
    chk("t1_end", per_q[j+9], 3'b010);
    cnt = 0;
    for (int i = start; i < per_q.size(); i++) if (per_q[i][1] == 1'b0) cnt++;
    chk("t1_oe_periods", cnt, 8);

    // Full/drop: shifter plus 4 FIFO slots accept 5 words; the 6th is dropped.
    for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
    start = per_q.size();
    for (int i = 0; i < 5; i++) wr0(w[i]);
    chk("t2_count_full", txc0, 3'd4);
    chk("t2_txintr", txi0, 1'b1);
    wr0(w[5]);
    chk("t2_count_drop", txc0, 3'd4);
    cyc(110);
    decode(start);
    chk("t2_nwords", dec_q.size(), 5);
    for (int i = 0; i < 5 && i < dec_q.size(); i++) chk("t2_word", dec_q[i], w[i]);
    for (int i = 1; i < pos_q.size(); i++) chk("t2_b2b", pos_q[i] - pos_q[i-1], 8);
    chk("t2_oe", oe_err, 0);
    chk("t2_drained", {txc0, txi0}, 4'b0000);

    // Back-to-back loopback.
    lb0 = 1'b1;
    cyc(2);
    chk("t3_ovr0", ovr0, 1'b0);
    start = per_q.size();
    wr0(8'h3C); wr0(8'hC3); wr0(8'h0F);
    cyc(80);
    decode(start);
    chk("t3_nframes", dec_q.size(), 3);
    for (int i = 1; i < pos_q.size(); i++) chk("t3_nogap", pos_q[i] - pos_q[i-1], 8);
    chk("t3_rxcount", rxc0, 3'd3);
    rd0("t3_rd0", 8'h3C); rd0("t3_rd1", 8'hC3); rd0("t3_rd2", 8'h0F);
    chk("t3_prdata_empty", prdata0, 8'h00);
    chk("t3_rxcount_empty", rxc0, 3'd0);

    // Overrun: five words into a 4-deep RX FIFO without reads.
    for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) wr0(w[i]);
    cyc(120);
    chk("t4_rxcount", rxc0, 3'd4);
    chk("t4_rxintr", rxi0, 1'b1);
    chk("t4_ovr", ovr0, 1'b1);
    for (int i = 0; i < 4; i++) rd0("t4_rd", w[i]);
    chk("t4_after", {rxc0, rxi0, ovr0}, 5'b00001);

    // Random loopback rounds against a queue model.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        w[0] = 8'($urandom);
        mq.push_back(w[0]);
        wr0(w[0]);
      end
      cyc(n * 16 + 40);
      chk("t5_rxcount", rxc0, 3'(n));
      while (mq.size() > 0) rd0("t5_rd", mq.pop_front());
    end

    // Mid-frame reset with two words still queued.
    for (int i = 0; i < 3; i++) wr0(8'($urandom));
    cyc(8);
    chk("t6_midframe", {oeb0, txc0}, {1'b0, 3'd2});
    #2;
    CLEAR_B = 1'b0;
    #1;
    chk_rst("t6_async");
    #3;
    CLEAR_B = 1'b1;
    cyc(1);
    chk("t6_txcount", txc0, 3'd0);
    start = per_q.size();
    cyc(40);
    cnt = 0;
    for (int i = start; i < per_q.size(); i++) if (per_q[i][2]) cnt++;
    chk("t6_no_frame", cnt, 0);
    chk("t6_rx_empty", rxc0, 3'd0);

    // Parametric instance: two back-to-back 12-bit frames from external pins.
    w2 = 12'($urandom);
    ext_period(1'b0, 1'b0); ext_period(1'b0, 1'b0);
    ext_period(1'b1, 1'b0);
    for (int k = 11; k >= 0; k--) ext_period(k == 0, 1'((12'hABC >> k) & 1));
    for (int k = 11; k >= 0; k--) ext_period(1'b0, 1'((w2 >> k) & 1));
    ext_period(1'b0, 1'b0); ext_period(1'b0, 1'b0);
    cyc(5);
    chk("t7_rxcount", rxc1, 4'd2);
    rd1("t7_rd0", 12'hABC);
    rd1("t7_rd1", w2);
    chk("t7_empty", {rxc1, ovr1, prdata1}, 17'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
